// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 arrow-key front end.
//   - Scan-code set 2 prefixes and the eight key codes (arrows and WASD)
//   - Key vector bit indices {R,L,D,U}
//   - Decoder state encoding
//   - map_key(): scan code + extended flag -> key bit index (or no hit)
package ps2_pkg;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  // Extended (E0-prefixed) arrow keys
  localparam logic [7:0] CODE_EXT_U = 8'h75;
  localparam logic [7:0] CODE_EXT_D = 8'h72;
  localparam logic [7:0] CODE_EXT_L = 8'h6B;
  localparam logic [7:0] CODE_EXT_R = 8'h74;
  // Non-extended WASD aliases
  localparam logic [7:0] CODE_W     = 8'h1D;
  localparam logic [7:0] CODE_S     = 8'h1B;
  localparam logic [7:0] CODE_A     = 8'h1C;
  localparam logic [7:0] CODE_D     = 8'h23;

  localparam int unsigned KEY_R = 3;
  localparam int unsigned KEY_L = 2;
  localparam int unsigned KEY_D = 1;
  localparam int unsigned KEY_U = 0;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } key_hit_t;

  function automatic key_hit_t map_key(input logic [7:0] code, input logic ext);
    key_hit_t m;
    m.hit = 1'b1;
    m.idx = 2'd0;
    if (ext) begin
      case (code)
        CODE_EXT_U: m.idx = 2'(KEY_U);
        CODE_EXT_D: m.idx = 2'(KEY_D);
        CODE_EXT_L: m.idx = 2'(KEY_L);
        CODE_EXT_R: m.idx = 2'(KEY_R);
        default:    m.hit = 1'b0;
      endcase
    end else begin
      case (code)
        CODE_W:  m.idx = 2'(KEY_U);
        CODE_S:  m.idx = 2'(KEY_D);
        CODE_A:  m.idx = 2'(KEY_L);
        CODE_D:  m.idx = 2'(KEY_R);
        default: m.hit = 1'b0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_arrow_keys_if.sv
// Bundle of PS/2 line inputs and decoded outputs of ps2_arrow_keys.
//   ps2_clk, ps2_data : raw PS/2 lines (driven by the device side)
//   key               : held keys {R,L,D,U}
//   scan_code         : last correctly framed byte
//   scan_valid        : one-cycle pulse when scan_code updates
//   frame_err         : one-cycle pulse on bad frame or timeout
// master = device/consumer side, slave = the decoder block.
interface ps2_arrow_keys_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] key;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  key, scan_code, scan_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output key, scan_code, scan_valid, frame_err
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver.
//   pclk, rst          : system clock, async active-high reset
//   ps2_clk, ps2_data  : raw asynchronous PS/2 lines
//   scan_code          : last byte with good start/stop/odd parity
//   scan_valid         : one-cycle pulse when scan_code updates
//   frame_err          : one-cycle pulse on framing/parity error or timeout
module ps2_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int unsigned FCntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned IdleW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic             clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
  logic             filt_q, filt_d;
  logic [FCntW-1:0] filt_cnt_q, filt_cnt_d;
  logic             fall_q;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [9:0]       shift_q, shift_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic [7:0]       code_q, code_d;
  logic             valid_q, valid_d, err_q, err_d;

  // Filtered level flips only after FILTER_LEN consecutive samples of the new value
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q != filt_q) begin
      if (filt_cnt_q == FCntW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  // shift_q collects start, data[7:0], parity LSB-first; after 10 bits start sits in [0]
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    idle_d    = idle_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (fall_q) begin
      idle_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        // data_sync_q is the stop bit; odd parity over data+parity
        if (!shift_q[0] && data_sync_q && (^shift_q[9:1])) begin
          code_d  = shift_q[8:1];
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        shift_d   = {data_sync_q, shift_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (idle_q == IdleW'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt_d = 4'd0;
        idle_d    = '0;
        err_d     = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end else begin
      idle_d = '0;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      fall_q      <= 1'b0;
      bit_cnt_q   <= 4'd0;
      shift_q     <= '0;
      idle_q      <= '0;
      code_q      <= 8'h00;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      fall_q      <= filt_q & ~filt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      idle_q      <= idle_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign scan_code  = code_q;
  assign scan_valid = valid_q;
  assign frame_err  = err_q;

endmodule

// File: rtl/ps2_arrow_keys.sv
// PS/2 keyboard front end producing a held-key vector for car_ctl.
//   pclk, rst : system clock, async active-high reset
//   bus       : ps2_arrow_keys_if.slave -- raw PS/2 lines in; key {R,L,D,U},
//               scan_code, scan_valid, frame_err out
// Decodes scan-code set 2 make/break (E0 / F0 prefixes) for arrows and WASD.
// Receive only: the PS/2 lines are never driven.
module ps2_arrow_keys #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65000
) (
  input  logic                   pclk,
  input  logic                   rst,
  ps2_arrow_keys_if.slave        bus
);
  import ps2_pkg::*;

  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;
  logic [1:0] state_q, state_d;
  logic [3:0] key_q, key_d;
  key_hit_t   hit;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .pclk      (pclk),
    .rst       (rst),
    .ps2_clk   (bus.ps2_clk),
    .ps2_data  (bus.ps2_data),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .frame_err (frame_err)
  );

  assign hit = map_key(scan_code, (state_q == ST_EXT) || (state_q == ST_EXT_BRK));

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    if (frame_err) begin
      // Drop any partial prefix sequence; held keys are kept
      state_d = ST_IDLE;
    end else if (scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code == PREFIX_EXT) begin
            state_d = ST_EXT;
          end else if (scan_code == PREFIX_BRK) begin
            state_d = ST_BRK;
          end else if (hit.hit) begin
            key_d[hit.idx] = 1'b1;
          end
        end
        ST_EXT: begin
          if (scan_code == PREFIX_BRK) begin
            state_d = ST_EXT_BRK;
          end else if (scan_code != PREFIX_EXT) begin
            state_d = ST_IDLE;
            if (hit.hit) key_d[hit.idx] = 1'b1;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          state_d = ST_IDLE;
          if (hit.hit) key_d[hit.idx] = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
    end
  end

  assign bus.key        = key_q;
  assign bus.scan_code  = scan_code;
  assign bus.scan_valid = scan_valid;
  assign bus.frame_err  = frame_err;

endmodule

// File: doc/ps2_arrow_keys.md
Name: ps2_arrow_keys

Overview:
- PS/2 keyboard front end; sits directly upstream of car_ctl and drives its 4-bit key input in place of, or ORed with, the debounced buttons.
- Receives device-to-host PS/2 frames and decodes scan-code set 2 make/break sequences for the arrow keys and WASD.
- Outputs a held-key vector {right, left, down, up}.
- Receive only; never drives ps2_clk or ps2_data.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronized samples needed to accept a new ps2_clk level.
- TIMEOUT_CYCLES, 65000: pclk cycles with no accepted falling edge that abort a partial frame (1 ms at 65 MHz).

Ports:
- pclk  in  1  system pixel clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- key  out  4  held keys {R,L,D,U}, bit3=R, bit0=U.
- scan_code  out  8  last correctly framed byte.
- scan_valid  out  1  one-cycle pulse when scan_code updates.
- frame_err  out  1  one-cycle pulse on a bad frame or timeout.

Behaviour:
- Reset: asynchronous, active-high. All outputs are 0: key=0, scan_code=8'h00, scan_valid=0, frame_err=0. Sync flops and filter are 1 (PS/2 idle). Bit counter=0, decoder state is IDLE.
- Input conditioning:
  - 2-FF synchronizer on both lines.
  - ps2_clk filter: the filtered level changes only after FILTER_LEN consecutive samples of the new value.
  - Falling edge = filtered level goes 1->0, registered. Data is sampled from the synchronized ps2_data on the same cycle.
- Frame receive (sub-module):
  - 11 bits: start (0), 8 data bits LSB first, odd parity, stop (1). A 4-bit bit counter runs 0..10.
  - On the 11th edge, check start==0, stop==1 and odd parity over data+parity.
  - Pass: scan_code<=data and scan_valid=1 on the next cycle.
  - Fail: frame_err=1 that cycle; scan_code is unchanged.
  - The counter returns to 0 either way.
- Timeout:
  - The idle counter clears on every accepted falling edge.
  - If counter!=0 and the idle count reaches TIMEOUT_CYCLES: bit counter goes to 0 and frame_err pulses once.
  - No pulse when idle with counter==0.
- Decoder FSM, advanced only on scan_valid:
  - States are IDLE, EXT, BRK and EXT_BRK.
  - IDLE: E0 -> EXT; F0 -> BRK; any other code -> apply make (non-extended), stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; other -> apply make (extended), go IDLE.
  - BRK: apply break (non-extended) -> IDLE.
  - EXT_BRK: apply break (extended) -> IDLE.
- Key map:
  - Extended: 75=U, 72=D, 6B=L, 74=R.
  - Non-extended: 1D=U (W), 1B=D (S), 1C=L (A), 23=R (D).
  - Make sets the bit and break clears it. Unmapped codes are ignored. E1 and other prefixes are unmapped and simply consumed.
- Timing: key updates on the cycle after scan_valid (1-cycle latency from scan_valid).
- Boundary conditions:
  - Key bits are independent; L and R may both be 1. car_ctl resolves conflicts.
  - Typematic repeats (make while held) leave the bit at 1.
  - A break for a key not held leaves it at 0.
  - An arrow and its WASD alias share one bit; the first break clears it.
  - frame_err while the decoder is in EXT, BRK or EXT_BRK forces IDLE, dropping the partial sequence; key is unchanged.
  - scan_valid and a timeout on the same cycle cannot occur, because the counter is 0 after a completed frame.
- Reset mid-frame or mid-sequence: immediate return to the reset values above, no pulses emitted.

Decomposition:
- Shared package ps2_pkg holds:
  - scan-code constants: PREFIX_EXT=8'hE0, PREFIX_BRK=8'hF0, the 8 key codes;
  - key bit indices: KEY_R=3, KEY_L=2, KEY_D=1, KEY_U=0;
  - the decoder state encoding.
- Sub-module ps2_rx holds the synchronizer, filter, edge detect, bit counter, parity/framing check and timeout. It outputs scan_code, scan_valid and frame_err.
- The top holds the decoder FSM and the key register.

Test Plan:
- Send frame 0xE0 then 0x75 (valid parity, 12.5 kHz PS/2 clock) -> two scan_valid pulses with scan_code E0 then 75; key=4'b0001 one cycle after the second pulse.
- With U held, send E0 F0 75 -> key=4'b0000; then send 1C -> key=4'b0100.
- Hold A (1C) and press/release Right (E0 74 / E0 F0 74) -> key goes 0100 -> 1100 -> 0100.
- Send 0x75 with a wrong parity bit -> frame_err pulses once, no scan_valid, key and scan_code unchanged. Then send a good E0 75 -> key bit0 set.
- Stop ps2_clk after 5 bits for more than TIMEOUT_CYCLES -> one frame_err pulse. A following full 0x1D frame decodes correctly and sets key bit0.
- Inject 3-cycle glitches on ps2_clk with FILTER_LEN=8 -> no bit accepted. Assert rst mid-frame during an E0 F0 sequence -> all outputs 0, decoder IDLE, next clean 1B frame sets key=4'b0010.
